// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared types for the matrix-multiply output-buffer reader
package matrix_mult_pkg;
  localparam int OB_WIDTH = 8;
  localparam int OB_COL = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ob_rd_state_e;
  typedef logic [OB_COL-1:0][OB_WIDTH-1:0] ob_row_t;
endpackage

// File: rtl/ob_mem_reader.sv
// ob_mem_reader: drains output-buffer rows to a valid/ready element stream with one-row prefetch
// Optional OB_READER_CHECKSUM_EN adds checksum_o, a running sum of accepted elements.
module ob_mem_reader
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COL = 4,
  parameter int O_SIZE = 256
)(
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [$clog2(O_SIZE)-1:0]     base_addr_i,
  input  logic [$clog2(O_SIZE):0]       n_rows_i,
  output logic                          ob_mem_cenb_o,
  output logic                          ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0]     ob_mem_addr_o,
  input  logic [COL-1:0][WIDTH-1:0]     ob_mem_data_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic                          done_o
`ifdef OB_READER_CHECKSUM_EN
  ,
  output logic [WIDTH+$clog2(O_SIZE*COL)-1:0] checksum_o
`endif
);
  localparam int AW = $clog2(O_SIZE);
  localparam int NW = AW + 1;
  localparam int IW = COL > 1 ? $clog2(COL) : 1;
  ob_rd_state_e state, state_n;
  logic [COL-1:0][WIDTH-1:0] cur, pf;
  logic cur_v, pf_v, ret;
  logic [IW-1:0] idx;
  logic [AW-1:0] base;
  logic [NW-1:0] n_rows, issued, delivered;
  logic start_ok, kill, issue, rd_pend, hs, row_end, last_hs;
  logic [AW-1:0] issue_addr;
  assign ob_mem_wenb_o = 1'b1;
  assign valid_o = cur_v;
  assign data_o = cur[idx];
  assign start_ok = state == IDLE && start_i;
  assign kill = state == RUN && abort_i;
  // a read is outstanding from request register until its data is captured
  assign rd_pend = !ob_mem_cenb_o || ret;
  assign hs = cur_v && ready_i;
  assign row_end = hs && idx == IW'(COL - 1);
  assign last_hs = row_end && delivered == n_rows - NW'(1);
  assign issue = (start_ok && n_rows_i != '0) ||
                 (state == RUN && !abort_i && issued < n_rows && !rd_pend && !pf_v);
  assign issue_addr = state == IDLE ? base_addr_i : AW'(base + issued[AW-1:0]);
  always_comb begin
    state_n = state;
    if (start_ok)
      state_n = n_rows_i != '0 ? RUN : DONE;
    else if (state == RUN && (abort_i || last_hs))
      state_n = abort_i ? IDLE : DONE;
    else if (state == DONE)
      state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      ob_mem_cenb_o <= 1'b1;
      ob_mem_addr_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      ret <= 1'b0;
      cur <= '0;
      pf <= '0;
      cur_v <= 1'b0;
      pf_v <= 1'b0;
      idx <= '0;
      base <= '0;
      n_rows <= '0;
      issued <= '0;
      delivered <= '0;
    end else begin
      state <= state_n;
      busy_o <= state_n != IDLE;
      done_o <= state_n == DONE;
      ob_mem_cenb_o <= !issue;
      if (issue) ob_mem_addr_o <= issue_addr;
      ret <= !ob_mem_cenb_o && !kill;
      if (start_ok) begin
        base <= base_addr_i;
        n_rows <= n_rows_i;
        issued <= NW'(n_rows_i != '0);
        delivered <= '0;
      end else if (kill) begin
        issued <= '0;
        delivered <= '0;
      end else begin
        if (issue) issued <= issued + NW'(1);
        if (row_end) delivered <= delivered + NW'(1);
      end
      if (kill || start_ok) begin
        cur_v <= 1'b0;
        pf_v <= 1'b0;
        idx <= '0;
      end else begin
        if (hs) idx <= row_end ? '0 : idx + IW'(1);
        if (row_end) begin
          cur_v <= pf_v;
          pf_v <= 1'b0;
          if (pf_v) cur <= pf;
        end
        // returning row goes straight to cur when cur is free at this edge
        if (ret) begin
          if (!cur_v || (row_end && !pf_v)) begin
            cur <= ob_mem_data_i;
            cur_v <= 1'b1;
          end else begin
            pf <= ob_mem_data_i;
            pf_v <= 1'b1;
          end
        end
      end
    end
  end
`ifdef OB_READER_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i || start_ok)
      checksum_o <= '0;
    else if (hs && !kill)
      checksum_o <= checksum_o + {{$clog2(O_SIZE*COL){1'b0}}, data_o};
  end
`endif
endmodule

// File: tb/tb_ob_mem_reader.sv
// tb_ob_mem_reader: directed bench with an element-queue model of the drain stream
module tb_ob_mem_reader;
  logic clk_i = 1'b0;
  logic rstn_i, start_i, abort_i, ready_i;
  logic [7:0] base_addr_i;
  logic [8:0] n_rows_i;
  logic ob_mem_cenb_o, ob_mem_wenb_o;
  logic [7:0] ob_mem_addr_o;
  logic [31:0] ob_mem_data_i;
  logic [7:0] data_o;
  logic valid_o, busy_o, done_o;
`ifdef OB_READER_CHECKSUM_EN
  logic [17:0] checksum_o;
`endif

  ob_mem_reader dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .n_rows_i(n_rows_i),
    .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o),
    .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_i(ob_mem_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o)
`ifdef OB_READER_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [256];
  always @(posedge clk_i) ob_mem_data_i <= !ob_mem_cenb_o ? mem[ob_mem_addr_o] : $urandom;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [7:0] addr_log[$];
  always @(posedge clk_i) if (rstn_i && !ob_mem_cenb_o) addr_log.push_back(ob_mem_addr_o);

  int passed = 0, total = 0;
  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  bit zero_req = 0, done_pend = 0, saw_done = 0, seen_valid = 0, first_hs_set = 0;
  bit stalled = 0, prev_req = 0;
  logic [7:0] prev_data;
  int first_cyc, first_hs, last_hs, s_cyc;

  always @(negedge clk_i) begin
    if (rstn_i) begin
      check("done_timing", done_o, done_pend);
      if (done_o) saw_done = 1;
      done_pend = zero_req;
      zero_req = 0;
      if (!ob_mem_cenb_o) check("one_outstanding", prev_req, 0);
      if (stalled) begin
        check("stall_valid", valid_o, 1);
        check("stall_data", data_o, prev_data);
      end
      if (valid_o && !abort_i) begin
        if (!seen_valid) begin
          first_cyc = cyc;
          seen_valid = 1;
        end
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          check("data", data_o, exp_q[0]);
          if (ready_i) begin
            rx.push_back(data_o);
            void'(exp_q.pop_front());
            last_hs = cyc + 1;
            if (!first_hs_set) begin
              first_hs = cyc + 1;
              first_hs_set = 1;
            end
            if (exp_q.size() == 0) done_pend = 1;
          end
        end
      end
      stalled = valid_o && !ready_i && !abort_i;
      prev_data = data_o;
      prev_req = !ob_mem_cenb_o;
    end
  end

  task automatic start_drain(logic [7:0] b, int n);
    logic [31:0] row;
    exp_q.delete();
    rx.delete();
    addr_log.delete();
    seen_valid = 0;
    first_hs_set = 0;
    saw_done = 0;
    for (int r = 0; r < n; r++) begin
      row = mem[8'(int'(b) + r)];
      for (int e = 0; e < 4; e++) exp_q.push_back(row[8*e +: 8]);
    end
    base_addr_i = b;
    n_rows_i = 9'(n);
    start_i = 1;
    if (n == 0) zero_req = 1;
    @(posedge clk_i);
    #1;
    start_i = 0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(bit toggle);
    for (int i = 0; i < 300 && !saw_done; i++) begin
      @(posedge clk_i);
      #1;
      if (toggle) ready_i = !ready_i;
    end
    check("drain_completes", saw_done, 1);
    ready_i = 1;
  endtask

  initial begin
    logic [7:0] wrap_exp[4];
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < 4; k++)
      mem[16 + k] = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
    mem[8'h20] = 32'hD4C3B2A1;
    rstn_i = 0; start_i = 0; abort_i = 0; ready_i = 1;
    base_addr_i = 0; n_rows_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cenb", ob_mem_cenb_o, 1);
    check("rst_wenb", ob_mem_wenb_o, 1);
    check("rst_addr", ob_mem_addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rstn_i = 1;
    @(posedge clk_i);
    #1;

    start_drain(8'h10, 4);
    check("busy_after_start", busy_o, 1);
    wait_done(0);
    check("first_valid_latency", first_cyc - s_cyc, 2);
    check("no_bubbles", last_hs - first_hs, 15);
    check("busy_cleared", busy_o, 0);
    check("rx_count", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) check("elem_literal", rx[i], i);
    check("addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("addr_seq", addr_log[i], 16 + i);
`ifdef OB_READER_CHECKSUM_EN
    check("checksum", checksum_o, 120);
`endif

    ready_i = 0;
    start_drain(8'h10, 4);
    wait_done(1);
    check("stall_rx_count", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) check("stall_elem_literal", rx[i], i);

    start_drain(8'hFE, 4);
    wait_done(0);
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("wrap_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("wrap_addr", addr_log[i], wrap_exp[i]);

    start_drain(8'h10, 0);
    check("zero_done", done_o, 1);
    check("zero_busy", busy_o, 1);
    repeat (3) @(posedge clk_i);
    #1;
    check("zero_no_read", addr_log.size(), 0);
    check("zero_idle", busy_o, 0);

    start_drain(8'h10, 4);
    for (int i = 0; i < 100 && rx.size() < 5; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("abort_reached_5", rx.size(), 5);
    ready_i = 0;
    abort_i = 1;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    abort_i = 0;
    check("abort_valid", valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_no_done", saw_done, 0);
    check("abort_stays_idle", valid_o, 0);
    ready_i = 1;
    start_drain(8'h20, 1);
    wait_done(0);
    check("restart_count", rx.size(), 4);
    if (rx.size() == 4) begin
      check("restart_e0", rx[0], 8'hA1);
      check("restart_e1", rx[1], 8'hB2);
      check("restart_e2", rx[2], 8'hC3);
      check("restart_e3", rx[3], 8'hD4);
    end
    check("restart_addr", addr_log.size() > 0 ? addr_log[0] : 0, 8'h20);
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
